// File: rtl/machine_pkg.sv
// Shared types, default parameters and rotate helpers for the machine digit bank.
package machine_pkg;

   localparam int NUM_DIGITS_DEF   = 5;
   localparam int DIGIT_W_DEF      = 4;
   localparam int ROT_DIV_DEF      = 1;
   localparam int SYNC_STAGES_DEF  = 2;
   localparam int DEBOUNCE_CYC_DEF = 16;
   localparam int ROT_MAX_W        = 32;

   typedef logic [DIGIT_W_DEF-1:0] digit_t;

   // Rotate the low w bits of v left by one; bits at and above w stay zero.
   function automatic logic [ROT_MAX_W-1:0] rotl1(input logic [ROT_MAX_W-1:0] v, input int w);
      logic [ROT_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < ROT_MAX_W; i++)
         if (i < w) r[(i + 1 == w) ? 0 : i + 1] = v[i];
      return r;
   endfunction

   function automatic logic [ROT_MAX_W-1:0] rotr1(input logic [ROT_MAX_W-1:0] v, input int w);
      logic [ROT_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < ROT_MAX_W; i++)
         if (i < w) r[i] = v[(i + 1 == w) ? 0 : i + 1];
      return r;
   endfunction

endpackage

// File: rtl/machine_btn_cond.sv
// One button: synchroniser, optional debounce (MACHINE_DIGIT_BANK_DEBOUNCE_EN), rise detect.
module machine_btn_cond
   import machine_pkg::*;
#(
   parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   level;
   logic                   prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
   end

`ifdef MACHINE_DIGIT_BANK_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYC + 1);

   logic          lvl_q;
   logic [CW-1:0] cnt_q;

   // A new level must persist DEBOUNCE_CYC cycles; any bounce back restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lvl_q <= 1'b0;
         cnt_q <= '0;
      end else if (sync_q[SYNC_STAGES-1] != lvl_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
            lvl_q <= sync_q[SYNC_STAGES-1];
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end else begin
         cnt_q <= '0;
      end
   end

   assign level = lvl_q;
`else
   assign level = sync_q[SYNC_STAGES-1];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_q <= 1'b0;
      else     prev_q <= level;
   end

   assign rise = level & ~prev_q;

endmodule

// File: rtl/machine_digit_bank.sv
// Digit bank: button-loaded upper digits plus a rotating digit 0.
// Optional build macro MACHINE_DIGIT_BANK_DEBOUNCE_EN adds button debounce.
module machine_digit_bank
   import machine_pkg::*;
#(
   parameter int NUM_DIGITS   = NUM_DIGITS_DEF,
   parameter int DIGIT_W      = DIGIT_W_DEF,
   parameter int ROT_DIV      = ROT_DIV_DEF,
   parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
   input  logic                          system1000,
   input  logic                          system1000_rst,
   input  logic [DIGIT_W-1:0]            sw,
   input  logic [NUM_DIGITS-2:0]         btn,
   input  logic                          rot_en,
   input  logic                          rot_dir,
   output logic [NUM_DIGITS*DIGIT_W-1:0] state,
   output logic                          load_pulse,
   output logic                          multi_err
);

   localparam int NB = NUM_DIGITS - 1;
   localparam int PW = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;

   logic [NB-1:0]                       rise;
   logic                                one_rise;
   logic                                many_rise;
   logic [NUM_DIGITS-1:1][DIGIT_W-1:0]  dig_q;
   logic [DIGIT_W-1:0]                  dig0_q;
   logic [PW-1:0]                       pre_q;
   logic                                rot_evt;

   for (genvar j = 0; j < NB; j++) begin : gen_btn
      machine_btn_cond #(
         .SYNC_STAGES  (SYNC_STAGES),
         .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_cond (
         .clk  (system1000),
         .rst  (system1000_rst),
         .btn  (btn[j]),
         .rise (rise[j])
      );
   end

   // Clearing the lowest set bit leaves something only if two or more bits were set.
   assign many_rise = (rise & (rise - 1'b1)) != '0;
   assign one_rise  = (rise != '0) && !many_rise;

   always_ff @(posedge system1000 or posedge system1000_rst) begin
      if (system1000_rst) begin
         dig_q      <= '0;
         load_pulse <= 1'b0;
         multi_err  <= 1'b0;
      end else begin
         load_pulse <= one_rise;
         multi_err  <= many_rise;
         for (int j = 0; j < NB; j++)
            if (one_rise && rise[j]) dig_q[j+1] <= sw;
      end
   end

   assign rot_evt = rot_en && (pre_q == PW'(ROT_DIV - 1));

   always_ff @(posedge system1000 or posedge system1000_rst) begin
      if (system1000_rst) begin
         pre_q  <= '0;
         dig0_q <= '0;
      end else if (rot_en) begin
         if (rot_evt) begin
            pre_q  <= '0;
            dig0_q <= rot_dir ? DIGIT_W'(rotr1(ROT_MAX_W'(dig0_q), DIGIT_W))
                              : DIGIT_W'(rotl1(ROT_MAX_W'(dig0_q), DIGIT_W));
         end else begin
            pre_q <= pre_q + 1'b1;
         end
      end
   end

   assign state = {dig_q, dig0_q};

endmodule

// File: tb/tb_machine_digit_bank.sv
// Scoreboard bench for machine_digit_bank: expected events queued by stimulus, checked by a monitor.
module tb_machine_digit_bank;

   localparam int SYNC = 2;
   localparam int DB   = 16;
`ifdef MACHINE_DIGIT_BANK_DEBOUNCE_EN
   localparam int LAT  = SYNC + DB;
`else
   localparam int LAT  = SYNC;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  sw = '0;
   logic [3:0]  btn = '0;
   logic        rot_en = 1'b0;
   logic        rot_dir = 1'b0;
   logic [19:0] state;
   logic        load_pulse;
   logic        multi_err;

   machine_digit_bank #(
      .NUM_DIGITS   (5),
      .DIGIT_W      (4),
      .ROT_DIV      (3),
      .SYNC_STAGES  (SYNC),
      .DEBOUNCE_CYC (DB)
   ) dut (
      .system1000     (clk),
      .system1000_rst (rst),
      .sw             (sw),
      .btn            (btn),
      .rot_en         (rot_en),
      .rot_dir        (rot_dir),
      .state          (state),
      .load_pulse     (load_pulse),
      .multi_err      (multi_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] st;
      logic        lp;
      logic        me;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   int          cyc = 0;
   int          vecs = 0;
   int          errs = 0;
   logic [19:0] prev_st = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Any state change or pulse is an event and must match the head of the queue.
   always @(posedge clk) begin
      #1;
      if (state !== prev_st || load_pulse !== 1'b0 || multi_err !== 1'b0) begin
         vecs++;
         if (q.size() == 0) begin
            errs++;
            $display("FAIL unexpected_event cyc=%0d state=%h lp=%b me=%b", cyc, state, load_pulse, multi_err);
         end else begin
            mon_e = q.pop_front();
            if (state !== mon_e.st || load_pulse !== mon_e.lp || multi_err !== mon_e.me || cyc != mon_e.cyc) begin
               errs++;
               $display("FAIL event got state=%h lp=%b me=%b cyc=%0d, want state=%h lp=%b me=%b cyc=%0d",
                        state, load_pulse, multi_err, cyc, mon_e.st, mon_e.lp, mon_e.me, mon_e.cyc);
            end
         end
      end
      prev_st = state;
   end

   task automatic push(input logic [19:0] st, input logic lp, input logic me, input int c);
      exp_t e;
      e.st = st; e.lp = lp; e.me = me; e.cyc = c;
      q.push_back(e);
   endtask

   task automatic check_zero(input string name);
      vecs++;
      if (state !== '0 || load_pulse !== 1'b0 || multi_err !== 1'b0) begin
         errs++;
         $display("FAIL %s got state=%h lp=%b me=%b, want all zero", name, state, load_pulse, multi_err);
      end
   endtask

   logic [3:0]  v_btn [8] = '{4'b1000, 4'b0101, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111, 4'b0001};
   logic [3:0]  v_sw  [8] = '{4'hA,    4'h5,    4'h7,    4'hC,    4'h3,    4'hF,    4'h0,    4'h0};
   logic        v_lp  [8] = '{1'b1,    1'b0,    1'b1,    1'b1,    1'b1,    1'b1,    1'b0,    1'b1};
   logic [19:0] v_st  [8] = '{20'hA0000, 20'hA0000, 20'hA0070, 20'hA0C70,
                              20'hA3C70, 20'hF3C70, 20'hF3C70, 20'hF3C00};

   initial begin
      int c2;
      int cr;
      #1 rst = 1'b1;
      #1 check_zero("reset_state");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      check_zero("idle_100");

      // Button loads and multi-press rejects.
      for (int i = 0; i < 8; i++) begin
         push(v_st[i], v_lp[i], !v_lp[i], cyc + 1 + LAT);
         sw  = v_sw[i];
         btn = v_btn[i];
         repeat (20) @(negedge clk);
         btn = '0;
         repeat (24) @(negedge clk);
      end

      // Seed digit 0 and rotate every 3 cycles.
      dut.dig0_q <= 4'b0001;
      push(20'hF3C01, 1'b0, 1'b0, cyc + 1);
      @(negedge clk);
      c2 = cyc;
      rot_en  = 1'b1;
      rot_dir = 1'b0;
      push(20'hF3C02, 1'b0, 1'b0, c2 + 3);
      push(20'hF3C04, 1'b0, 1'b0, c2 + 6);
      push(20'hF3C08, 1'b0, 1'b0, c2 + 9);
      push(20'hF3C01, 1'b0, 1'b0, c2 + 12);
      repeat (12) @(negedge clk);
      rot_dir = 1'b1;
      push(20'hF3C08, 1'b0, 1'b0, c2 + 15);
      repeat (4) @(negedge clk);
      rot_dir = 1'b0;
      push(20'hF3C01, 1'b0, 1'b0, c2 + 18);
      repeat (3) @(negedge clk);

      // Reset mid-count with a press in flight; held press loads once afterwards.
      sw  = 4'h9;
      btn = 4'b0010;
      @(negedge clk);
      rst = 1'b1;
      push(20'h00000, 1'b0, 1'b0, c2 + 21);
      #1 check_zero("async_reset");
      repeat (3) @(negedge clk);
      cr = cyc;
      rst = 1'b0;
      push(20'h00900, 1'b1, 1'b0, cr + 1 + LAT);
      repeat (20) @(negedge clk);
      btn = '0;
      rot_en = 1'b0;
      repeat (24) @(negedge clk);

`ifdef MACHINE_DIGIT_BANK_DEBOUNCE_EN
      sw  = 4'h6;
      btn = 4'b0001;
      repeat (10) @(negedge clk);
      btn = '0;
      repeat (30) @(negedge clk);
      push(20'h00960, 1'b1, 1'b0, cyc + 1 + LAT);
      btn = 4'b0001;
      repeat (30) @(negedge clk);
      btn = '0;
      repeat (24) @(negedge clk);
`endif

      for (int t = 0; t < 200 && q.size() != 0; t++) @(negedge clk);
      while (q.size() != 0) begin
         mon_e = q.pop_front();
         vecs++;
         errs++;
         $display("FAIL missing_event want state=%h lp=%b me=%b cyc=%0d", mon_e.st, mon_e.lp, mon_e.me, mon_e.cyc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
